rv32i_host_mailbox: RTL and testbench

Memory-mapped test-host responder on the SoC data bus. It is the device-side counterpart of the core's load/store port. Firmware signals test completion through a TOHOST register, emitting riscv-tests exit codes. It also streams console bytes through a small FIFO to a ready/valid character sink. This lets simulation or FPGA builds detect pass/fail and print text without probing internal base-register state.

---
 rtl/rv32i_host_mailbox.sv | 180 ++++++++++++++++++
 tb/tb_rv32i_host_mailbox.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_host_mailbox.sv
// Test-host mailbox on the data bus: TOHOST exit-code capture, FROMHOST scratch,
// and a console byte FIFO drained by a ready/valid character sink.
module rv32i_host_mailbox #(
   parameter logic [31:0] BASE_ADDR  = 32'h0000_8000,
   parameter int          FIFO_DEPTH = 8
)(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_stb_data,
   input  logic        i_wr_en,
   input  logic [31:0] i_data_addr,
   input  logic [31:0] i_data_in,
   input  logic [3:0]  i_wr_mask,
   output logic [31:0] o_data_out,
   output logic        o_ack,
   output logic        o_char_valid,
   output logic [7:0]  o_char_data,
   input  logic        i_char_ready,
   output logic        o_done,
   output logic        o_pass,
   output logic [30:0] o_exit_code
);
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   localparam logic [1:0] S_IDLE       = 2'd0;
   localparam logic [1:0] S_ACK        = 2'd1;
   localparam logic [1:0] S_WAIT_SPACE = 2'd2;

   localparam logic [1:0] OFF_TOHOST   = 2'd0;
   localparam logic [1:0] OFF_CONSOLE  = 2'd1;
   localparam logic [1:0] OFF_STATUS   = 2'd2;
   localparam logic [1:0] OFF_FROMHOST = 2'd3;

   logic [1:0]       r_state;
   logic [31:0]      r_data_out;
   logic [31:0]      r_tohost;
   logic [31:0]      r_fromhost;
   logic             r_done;
   logic             r_pass;
   logic [30:0]      r_exit_code;
   logic [7:0]       r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;

   logic             w_hit;
   logic [1:0]       w_off;
   logic             w_idle_hit;
   logic             w_full;
   logic             w_empty;
   logic             w_con_wr;
   logic             w_push;
   logic             w_pop;
   logic             w_to_wr;
   logic             w_fh_wr;
   logic [31:0]      w_to_new;
   logic [31:0]      w_fh_new;
   logic [7:0]       w_count8;
   logic [31:0]      w_rd_data;
   logic             w_unused;

   function automatic logic [31:0] merge_lanes(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  mask);
      logic [31:0] res;
      for (int b = 0; b < 4; b++)
         res[b*8 +: 8] = mask[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
      return res;
   endfunction

   assign w_unused   = &{1'b0, i_data_addr[1:0]};
   assign w_hit      = i_stb_data && (i_data_addr[31:4] == BASE_ADDR[31:4]);
   assign w_off      = i_data_addr[3:2];
   assign w_idle_hit = (r_state == S_IDLE) && w_hit;
   assign w_full     = (r_count == CNT_W'(FIFO_DEPTH));
   assign w_empty    = (r_count == '0);
   assign w_con_wr   = w_idle_hit && i_wr_en && (w_off == OFF_CONSOLE);

   // A stalled console write only pushes once full is seen low on a registered count.
   assign w_push = i_wr_mask[0] && !w_full &&
                   (w_con_wr || (r_state == S_WAIT_SPACE));
   assign w_pop  = !w_empty && i_char_ready;

   assign w_to_wr  = w_idle_hit && i_wr_en && (w_off == OFF_TOHOST);
   assign w_fh_wr  = w_idle_hit && i_wr_en && (w_off == OFF_FROMHOST);
   assign w_to_new = merge_lanes(r_tohost, i_data_in, i_wr_mask);
   assign w_fh_new = merge_lanes(r_fromhost, i_data_in, i_wr_mask);
   assign w_count8 = 8'(r_count);

   always_comb begin
      w_rd_data = 32'h0;
      case (w_off)
         OFF_TOHOST:   w_rd_data = r_tohost;
         OFF_CONSOLE:  w_rd_data = 32'h0;
         OFF_STATUS:   w_rd_data = {16'h0, w_count8, 5'h0, w_full, w_empty, r_done};
         OFF_FROMHOST: w_rd_data = r_fromhost;
         default:      w_rd_data = 32'h0;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= S_IDLE;
         r_data_out <= 32'h0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_hit) begin
                  if (w_con_wr && w_full) begin
                     r_state <= S_WAIT_SPACE;
                  end else begin
                     r_state    <= S_ACK;
                     r_data_out <= i_wr_en ? 32'h0 : w_rd_data;
                  end
               end
            end
            S_ACK: r_state <= S_IDLE;
            S_WAIT_SPACE: begin
               if (!w_full) begin
                  r_state    <= S_ACK;
                  r_data_out <= 32'h0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_tohost    <= 32'h0;
         r_fromhost  <= 32'h0;
         r_done      <= 1'b0;
         r_pass      <= 1'b0;
         r_exit_code <= 31'h0;
      end else begin
         if (w_to_wr) begin
            r_tohost <= w_to_new;
            // Only the first finishing write is recorded; later ones just update TOHOST.
            if (w_to_new[0] && !r_done) begin
               r_done      <= 1'b1;
               r_pass      <= (w_to_new == 32'h1);
               r_exit_code <= w_to_new[31:1];
            end
         end
         if (w_fh_wr)
            r_fromhost <= w_fh_new;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push && !i_rst)
         r_mem[r_wr_ptr] <= i_data_in[7:0];
   end

   assign o_data_out   = r_data_out;
   assign o_ack        = (r_state == S_ACK);
   assign o_char_valid = !w_empty;
   assign o_char_data  = w_empty ? 8'h0 : r_mem[r_rd_ptr];
   assign o_done       = r_done;
   assign o_pass       = r_pass;
   assign o_exit_code  = r_exit_code;
endmodule

// File: tb/tb_rv32i_host_mailbox.sv
// Directed bench for rv32i_host_mailbox: exit codes, scratch masks, console FIFO
// ordering, backpressure stall/release and reset during a stalled write.
module tb_rv32i_host_mailbox;
   localparam logic [31:0] BASE = 32'h0000_8000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stb = 1'b0;
   logic        wr_en = 1'b0;
   logic [31:0] addr = 32'h0;
   logic [31:0] wdata = 32'h0;
   logic [3:0]  mask = 4'h0;
   logic [31:0] rdata;
   logic        ack;
   logic        char_valid;
   logic [7:0]  char_data;
   logic        char_ready = 1'b0;
   logic        done;
   logic        pass;
   logic [30:0] exit_code;

   int n_checks = 0;
   int n_err    = 0;
   logic [7:0] rxq[$];

   rv32i_host_mailbox #(.BASE_ADDR(BASE), .FIFO_DEPTH(8)) dut (
      .i_clk(clk), .i_rst(rst), .i_stb_data(stb), .i_wr_en(wr_en),
      .i_data_addr(addr), .i_data_in(wdata), .i_wr_mask(mask),
      .o_data_out(rdata), .o_ack(ack), .o_char_valid(char_valid),
      .o_char_data(char_data), .i_char_ready(char_ready),
      .o_done(done), .o_pass(pass), .o_exit_code(exit_code)
   );

   always #5 clk = ~clk;

   always @(negedge clk)
      if (!rst && char_valid && char_ready) rxq.push_back(char_data);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] m, output logic [31:0] rd, output int lat);
      @(posedge clk); #1;
      stb = 1'b1; wr_en = wr; addr = a; wdata = d; mask = m;
      lat = -1; rd = 32'h0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (ack) begin lat = i; rd = rdata; break; end
      end
      stb = 1'b0; wr_en = 1'b0;
   endtask

   task automatic wr32(input string tag, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] m);
      logic [31:0] rd;
      int lat;
      xfer(1'b1, a, d, m, rd, lat);
      chk(tag, 32'(lat), 32'd1);
   endtask

   task automatic rd32(input string tag, input logic [31:0] a, input logic [31:0] exp);
      logic [31:0] rd;
      int lat;
      xfer(1'b0, a, 32'h0, 4'h0, rd, lat);
      chk({tag, "_lat"}, 32'(lat), 32'd1);
      chk(tag, rd, exp);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      logic [31:0] rd;
      int lat;
      int acks;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_ack", {31'h0, ack}, 32'h0);
      chk("rst_done", {31'h0, done}, 32'h0);
      chk("rst_pass", {31'h0, pass}, 32'h0);
      chk("rst_exit", {1'b0, exit_code}, 32'h0);
      chk("rst_data", rdata, 32'h0);
      chk("rst_cvalid", {31'h0, char_valid}, 32'h0);
      rst = 1'b0;

      // Pass code
      wr32("to1_lat", BASE + 32'h0, 32'h1, 4'hF);
      chk("to1_done", {31'h0, done}, 32'h1);
      chk("to1_pass", {31'h0, pass}, 32'h1);
      chk("to1_exit", {1'b0, exit_code}, 32'h0);
      rd32("to1_status", BASE + 32'h8, 32'h0000_0003);

      // Failing exit code stays sticky
      do_reset();
      wr32("to7_lat", BASE + 32'h0, 32'h7, 4'hF);
      chk("to7_done", {31'h0, done}, 32'h1);
      chk("to7_pass", {31'h0, pass}, 32'h0);
      chk("to7_exit", {1'b0, exit_code}, 32'h3);
      wr32("to7b_lat", BASE + 32'h0, 32'h1, 4'hF);
      chk("to7b_pass", {31'h0, pass}, 32'h0);
      chk("to7b_exit", {1'b0, exit_code}, 32'h3);
      rd32("to7b_rd", BASE + 32'h0, 32'h1);

      // Even value never finishes
      do_reset();
      wr32("to2_lat", BASE + 32'h0, 32'h2, 4'hF);
      chk("to2_done", {31'h0, done}, 32'h0);
      rd32("to2_rd", BASE + 32'h0, 32'h2);

      // FROMHOST lane masks, address low bits ignored
      wr32("fh_lat", BASE + 32'hC, 32'hDEAD_BEEF, 4'b0011);
      rd32("fh_rd", BASE + 32'hF, 32'h0000_BEEF);
      wr32("fh2_lat", BASE + 32'hC, 32'h1234_5678, 4'b1000);
      rd32("fh2_rd", BASE + 32'hC, 32'h1200_BEEF);

      // Miss is ignored
      xfer(1'b1, BASE + 32'h10, 32'hFFFF_FFFF, 4'hF, rd, lat);
      chk("miss_noack", 32'(lat), 32'hFFFF_FFFF);
      rd32("miss_fh", BASE + 32'hC, 32'h1200_BEEF);

      // Console with mask[0]=0 acks without push; console read is zero
      wr32("cm0_lat", BASE + 32'h4, 32'h0000_0055, 4'b1110);
      chk("cm0_cvalid", {31'h0, char_valid}, 32'h0);
      rd32("con_rd", BASE + 32'h4, 32'h0);

      // ABC streamed with sink ready
      rxq.delete();
      char_ready = 1'b1;
      wr32("abc_a", BASE + 32'h4, 32'h41, 4'h1);
      wr32("abc_b", BASE + 32'h4, 32'h42, 4'h1);
      wr32("abc_c", BASE + 32'h4, 32'h43, 4'h1);
      repeat (3) @(posedge clk);
      #1;
      chk("abc_n", rxq.size(), 32'd3);
      if (rxq.size() == 3) begin
         chk("abc_0", {24'h0, rxq[0]}, 32'h41);
         chk("abc_1", {24'h0, rxq[1]}, 32'h42);
         chk("abc_2", {24'h0, rxq[2]}, 32'h43);
      end
      chk("abc_empty", {31'h0, char_valid}, 32'h0);

      // Backpressure: fill, stall the 9th, release one slot
      rxq.delete();
      char_ready = 1'b0;
      for (int i = 0; i < 8; i++)
         wr32("fill_lat", BASE + 32'h4, 32'h10 + i, 4'h1);
      rd32("full_status", BASE + 32'h8, 32'h0000_0804);
      @(posedge clk); #1;
      stb = 1'b1; wr_en = 1'b1; addr = BASE + 32'h4; wdata = 32'h18; mask = 4'h1;
      acks = 0;
      repeat (5) begin
         @(posedge clk); #1;
         if (ack) acks++;
      end
      chk("stall_noack", 32'(acks), 32'd0);
      chk("stall_head", {24'h0, char_data}, 32'h10);
      char_ready = 1'b1;
      @(posedge clk); #1;
      char_ready = 1'b0;
      lat = -1;
      for (int i = 1; i <= 10; i++) begin
         if (ack) begin lat = i; break; end
         @(posedge clk); #1;
      end
      chk("stall_release", 32'(lat), 32'd2);
      stb = 1'b0; wr_en = 1'b0;
      rd32("stall_status", BASE + 32'h8, 32'h0000_0804);
      char_ready = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      chk("drain_n", rxq.size(), 32'd9);
      if (rxq.size() == 9)
         for (int i = 0; i < 9; i++)
            chk("drain_byte", {24'h0, rxq[i]}, 32'h10 + i);
      rd32("drain_status", BASE + 32'h8, 32'h0000_0002);

      // Reset while stalled in WAIT_SPACE
      wr32("w5_lat", BASE + 32'h0, 32'h5, 4'hF);
      char_ready = 1'b0;
      for (int i = 0; i < 8; i++)
         wr32("fill2_lat", BASE + 32'h4, 32'h20 + i, 4'h1);
      @(posedge clk); #1;
      stb = 1'b1; wr_en = 1'b1; addr = BASE + 32'h4; wdata = 32'h99; mask = 4'h1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      chk("wrst_ack", {31'h0, ack}, 32'h0);
      chk("wrst_cvalid", {31'h0, char_valid}, 32'h0);
      chk("wrst_cdata", {24'h0, char_data}, 32'h0);
      chk("wrst_data", rdata, 32'h0);
      chk("wrst_done", {31'h0, done}, 32'h0);
      chk("wrst_pass", {31'h0, pass}, 32'h0);
      chk("wrst_exit", {1'b0, exit_code}, 32'h0);
      stb = 1'b0; wr_en = 1'b0;
      rst = 1'b0;
      acks = 0;
      repeat (3) begin
         @(posedge clk); #1;
         if (ack || char_valid) acks++;
      end
      chk("wrst_quiet", 32'(acks), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
